ssd_scan_buffer: RTL and testbench

//  Downstream of the scan-code-to-segment decoder. Captures each decoded 8-bit segment pattern into a

---
 rtl/ssd_scan_buffer_pkg.sv | 18 +
 rtl/ssd_scan_buffer_if.sv | 17 +
 rtl/ssd_scan_buffer_scan_counter.sv | 30 +++
 rtl/ssd_scan_buffer.sv | 69 ++++++
 tb/tb_ssd_scan_buffer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ssd_scan_buffer_pkg.sv
// Shared constants and types for the scan-code display path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ssd_scan_buffer_pkg;

  typedef logic [7:0] seg_t;

  // Segment patterns are {a,b,c,d,e,f,g,dp}, active-low.
  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t SEG_DOT   = 8'hFE;

  localparam int N_DIGITS_DEF  = 4;
  localparam int SCAN_BITS_DEF = 17;

  // Digit enables are active-low; idle selects digit 0 only.
  localparam logic [7:0] DIGIT_IDLE = 8'hFE;

endpackage

// File: rtl/ssd_scan_buffer_if.sv
// Bundles decoder-side inputs and display-side outputs of the scan buffer.
// Latency: n/a (wires only).
// Backpressure: none; inputs are edge-detected levels, outputs free-running.
interface ssd_scan_buffer_if
  import ssd_scan_buffer_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF
);
  seg_t                seg_in;
  logic                seg_valid;
  logic                clear;
  logic [N_DIGITS-1:0] ssd_ctl;
  seg_t                ssd_out;

  modport master (output seg_in, seg_valid, clear, input ssd_ctl, ssd_out);
  modport slave  (input seg_in, seg_valid, clear, output ssd_ctl, ssd_out);
endinterface

// File: rtl/ssd_scan_buffer_scan_counter.sv
// Prescaler plus digit index that selects which display digit is lit.
// Latency: idx advances one cycle after the prescaler reaches all-ones.
// Backpressure: none; free-running.
module ssd_scan_counter #(
  parameter int SCAN_BITS = 17,
  parameter int N_DIGITS  = 4,
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx
);

  logic [SCAN_BITS-1:0] presc;

  // Count clk cycles; step the digit index each time the prescaler wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (presc == {SCAN_BITS{1'b1}}) begin
        if (idx == IDX_W'(N_DIGITS - 1)) idx <= '0;
        else                             idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd_scan_buffer.sv
// Shift buffer of decoded segment patterns, time-multiplexed onto a common-anode display.
// Latency: buffer updates 1 cycle after an input rising edge; ssd_out follows 1 cycle later.
// Backpressure: none; every seg_valid rising edge is accepted, clear wins over load.
module ssd_scan_buffer
  import ssd_scan_buffer_pkg::*;
#(
  parameter int N_DIGITS  = N_DIGITS_DEF,
  parameter int SCAN_BITS = SCAN_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  ssd_scan_buffer_if.slave   bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [IDX_W-1:0] idx;
  logic             seg_valid_q;
  logic             clear_q;
  logic             load;
  logic             clr;
  seg_t             seg_buf [N_DIGITS];

  ssd_scan_counter #(
    .SCAN_BITS (SCAN_BITS),
    .N_DIGITS  (N_DIGITS)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (idx)
  );

  // A held key yields exactly one action, on its rising edge.
  assign load = bus.seg_valid & ~seg_valid_q;
  assign clr  = bus.clear & ~clear_q;

  // Previous-cycle copies of the input levels for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_valid_q <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      seg_valid_q <= bus.seg_valid;
      clear_q     <= bus.clear;
    end
  end

  // Newest pattern enters at digit 0; clear takes priority and drops a simultaneous load.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < N_DIGITS; i++) seg_buf[i] <= SEG_BLANK;
    end else if (load) begin
      for (int i = N_DIGITS - 1; i > 0; i--) seg_buf[i] <= seg_buf[i-1];
      seg_buf[0] <= bus.seg_in;
    end
  end

  // Enable and segment drive switch on the same edge so digits never ghost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ssd_ctl <= DIGIT_IDLE[N_DIGITS-1:0];
      bus.ssd_out <= SEG_BLANK;
    end else begin
      bus.ssd_ctl <= ~(N_DIGITS'(1) << idx);
      bus.ssd_out <= seg_buf[idx];
    end
  end

endmodule

// File: tb/tb_ssd_scan_buffer.sv
// Directed bench for ssd_scan_buffer with a cycle model feeding an expected-output queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_ssd_scan_buffer;

  localparam int N  = 4;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ssd_scan_buffer_if #(.N_DIGITS(N)) bus ();

  ssd_scan_buffer #(.N_DIGITS(N), .SCAN_BITS(SB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] ctl;
    logic [7:0] out;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: buffer, prescaler, digit index, edge registers.
  logic [7:0] mbuf [N];
  int         mpre;
  int         midx;
  logic       msvq;
  logic       mclq;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the registered outputs, then compare after the edge.
  task automatic step(input logic r, input logic sv, input logic cl, input logic [7:0] si);
    exp_t e;
    exp_t got;
    rst_n         = r;
    bus.seg_valid = sv;
    bus.clear     = cl;
    bus.seg_in    = si;
    if (!r) begin
      for (int i = 0; i < N; i++) mbuf[i] = 8'hFF;
      mpre  = 0;
      midx  = 0;
      msvq  = 1'b0;
      mclq  = 1'b0;
      e.ctl = 4'b1110;
      e.out = 8'hFF;
    end else begin
      e.ctl = ~(4'b0001 << midx);
      e.out = mbuf[midx];
      if (cl && !mclq) begin
        for (int i = 0; i < N; i++) mbuf[i] = 8'hFF;
      end else if (sv && !msvq) begin
        for (int i = N - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
        mbuf[0] = si;
      end
      msvq = sv;
      mclq = cl;
      if (mpre == (1 << SB) - 1) begin
        mpre = 0;
        midx = (midx + 1) % N;
      end else begin
        mpre++;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 8'h01, 8'h00);
    end else begin
      got = sb_q.pop_front();
      check("ctl", {4'b0, bus.ssd_ctl}, {4'b0, got.ctl});
      check("out", bus.ssd_out, got.out);
    end
  endtask

  initial begin
    int n1110, n1101, n1011, n0111, nff, n9f, n01, n6d;
    bit found;

    bus.seg_valid = 1'b0;
    bus.clear     = 1'b0;
    bus.seg_in    = 8'h00;
    rst_n         = 1'b0;

    // Reset state.
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    check("rst_ctl", {4'b0, bus.ssd_ctl}, 8'h0E);
    check("rst_out", bus.ssd_out, 8'hFF);

    // 1: free scan, each digit selected for 8 of 32 cycles, display blank.
    n1110 = 0; n1101 = 0; n1011 = 0; n0111 = 0; nff = 0;
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, 8'h00);
      if (bus.ssd_ctl == 4'b1110) n1110++;
      if (bus.ssd_ctl == 4'b1101) n1101++;
      if (bus.ssd_ctl == 4'b1011) n1011++;
      if (bus.ssd_ctl == 4'b0111) n0111++;
      if (bus.ssd_out == 8'hFF)   nff++;
    end
    check("scan_d0", 8'(n1110), 8'd8);
    check("scan_d1", 8'(n1101), 8'd8);
    check("scan_d2", 8'(n1011), 8'd8);
    check("scan_d3", 8'(n0111), 8'd8);
    check("scan_blank", 8'(nff), 8'd32);

    // 2: held seg_valid loads once; 9F only on digit 0.
    for (int i = 0; i < 10; i++) step(1, 1, 0, 8'h9F);
    n9f = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'h00);
      if (bus.ssd_out == 8'h9F) begin
        n9f++;
        check("one_on_d0", {4'b0, bus.ssd_ctl}, 8'h0E);
      end
    end
    check("one_count", 8'(n9f), 8'd4);

    // 3: five loads, oldest discarded.
    step(1, 1, 0, 8'h03); step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h9F); step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h25); step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h0D); step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h99); step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'h00);
      case (bus.ssd_ctl)
        4'b1110: check("shift_d0", bus.ssd_out, 8'h99);
        4'b1101: check("shift_d1", bus.ssd_out, 8'h0D);
        4'b1011: check("shift_d2", bus.ssd_out, 8'h25);
        4'b0111: check("shift_d3", bus.ssd_out, 8'h9F);
        default: check("shift_ctl", {4'b0, bus.ssd_ctl}, 8'h0E);
      endcase
    end

    // 4: clear and load in the same cycle, clear wins.
    step(1, 1, 1, 8'h01);
    step(1, 0, 0, 8'h00);
    nff = 0; n01 = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'h00);
      if (bus.ssd_out == 8'hFF) nff++;
      if (bus.ssd_out == 8'h01) n01++;
    end
    check("clr_blank", 8'(nff), 8'd16);
    check("clr_no01", 8'(n01), 8'd0);

    // 5: reset mid-scan with a full buffer.
    step(1, 1, 0, 8'h11); step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h22); step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h33); step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h44); step(1, 0, 0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 8'h00);
      if (bus.ssd_ctl == 4'b1011) found = 1'b1;
    end
    check("find_d2", {7'b0, found}, 8'h01);
    step(0, 0, 0, 8'h00);
    check("mid_rst_ctl", {4'b0, bus.ssd_ctl}, 8'h0E);
    check("mid_rst_out", bus.ssd_out, 8'hFF);
    nff = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'h00);
      if (bus.ssd_out == 8'hFF) nff++;
    end
    check("mid_rst_blank", 8'(nff), 8'd16);

    // 6: seg_valid already high through reset release loads exactly once.
    step(0, 1, 0, 8'h6D);
    step(0, 1, 0, 8'h6D);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 8'h6D);
    n6d = 0; nff = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'h00);
      if (bus.ssd_out == 8'h6D) n6d++;
      if (bus.ssd_out == 8'hFF) nff++;
    end
    check("rel_load", 8'(n6d), 8'd4);
    check("rel_rest", 8'(nff), 8'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
